// File: rtl/spi_reg_bank_pkg.sv
// Shared types for the SPI register bank: frame FSM states and bit-counter sizing.
package spi_reg_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } spi_state_e;

  // Counts up to ADDR_W+DATA_W; 7 bits leaves headroom for the widest legal frame.
  localparam int CNT_W = 7;

endpackage

// File: rtl/spi_reg_bank_sync_edge.sv
// Synchronises the asynchronous SPI pins into the system clock and flags SCLK rising edges.
// All three outputs carry the same SYNC_STAGES+1 cycle latency so MOSI lines up with its rise flag.
module spi_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sclk,
  input  logic csb,
  input  logic mosi,
  output logic sclk_rise,
  output logic csb_sync,
  output logic mosi_sync
);

  logic [SYNC_STAGES-1:0] sclk_sync_r;
  logic [SYNC_STAGES-1:0] csb_sync_r;
  logic [SYNC_STAGES-1:0] mosi_sync_r;
  logic                   sclk_d_r;

  // Synchroniser chains, idle levels on reset, plus registered rise detect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_r <= {SYNC_STAGES{1'b0}};
      csb_sync_r  <= {SYNC_STAGES{1'b1}};
      mosi_sync_r <= {SYNC_STAGES{1'b0}};
      sclk_d_r    <= 1'b0;
      sclk_rise   <= 1'b0;
      csb_sync    <= 1'b1;
      mosi_sync   <= 1'b0;
    end else begin
      sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], sclk};
      csb_sync_r  <= {csb_sync_r[SYNC_STAGES-2:0], csb};
      mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], mosi};
      sclk_d_r    <= sclk_sync_r[SYNC_STAGES-1];
      sclk_rise   <= sclk_sync_r[SYNC_STAGES-1] & ~sclk_d_r;
      csb_sync    <= csb_sync_r[SYNC_STAGES-1];
      mosi_sync   <= mosi_sync_r[SYNC_STAGES-1];
    end
  end

endmodule

// File: rtl/spi_reg_bank.sv
// SPI-slave register bank: address+data frames land either straight in the live registers
// (immediate) or in a pending buffer that only goes live on i_commit (deferred).
module spi_reg_bank
  import spi_reg_pkg::*;
#(
  parameter int                            NUM_REGS       = 8,
  parameter int                            DATA_W         = 24,
  parameter int                            ADDR_W         = 4,
  parameter int                            SYNC_STAGES    = 2,
  parameter logic [NUM_REGS-1:0]           IMMEDIATE_MASK = {NUM_REGS{1'b0}},
  parameter logic [NUM_REGS*DATA_W-1:0]    RESET_VAL      = {(NUM_REGS*DATA_W){1'b0}}
) (
  input  logic                       i_clk,
  input  logic                       i_reset_n,
  input  logic                       i_sclk,
  input  logic                       i_csb,
  input  logic                       i_mosi,
  input  logic                       i_commit,
  output logic [NUM_REGS*DATA_W-1:0] o_regs,
  output logic                       o_wr_strobe,
  output logic [ADDR_W-1:0]          o_wr_addr,
  output logic                       o_pending,
  output logic                       o_frame_err
);

  localparam int FRAME_LEN = ADDR_W + DATA_W;

  logic              rise_s;
  logic              csb_s;
  logic              mosi_s;
  spi_state_e        state_r;
  logic [CNT_W-1:0]  bit_cnt_r;
  logic [ADDR_W-1:0] addr_sh_r;
  logic [DATA_W-1:0] data_sh_r;
  logic [DATA_W-1:0] word_s;
  logic              last_bit_s;
  logic              addr_ok_s;
  logic              cap_s;
  logic [DATA_W-1:0] live_r [NUM_REGS];
  logic [DATA_W-1:0] pend_r [NUM_REGS];
  logic [NUM_REGS-1:0] dirty_r;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk       (i_clk),
    .rst_n     (i_reset_n),
    .sclk      (i_sclk),
    .csb       (i_csb),
    .mosi      (i_mosi),
    .sclk_rise (rise_s),
    .csb_sync  (csb_s),
    .mosi_sync (mosi_s)
  );

  // The final data bit is folded in combinationally so the write happens on the last rise itself.
  assign word_s     = DATA_W'({data_sh_r, mosi_s});
  assign last_bit_s = (state_r == DATA) && rise_s && !csb_s &&
                      (bit_cnt_r == CNT_W'(FRAME_LEN - 1));
  assign addr_ok_s  = (int'(addr_sh_r) < NUM_REGS);
  assign cap_s      = last_bit_s && addr_ok_s;

  // Frame FSM: bit counting, shift registers, strobe/address/error outputs.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_r     <= IDLE;
      bit_cnt_r   <= {CNT_W{1'b0}};
      addr_sh_r   <= {ADDR_W{1'b0}};
      data_sh_r   <= {DATA_W{1'b0}};
      o_wr_strobe <= 1'b0;
      o_wr_addr   <= {ADDR_W{1'b0}};
      o_frame_err <= 1'b0;
    end else begin
      o_wr_strobe <= 1'b0;
      o_frame_err <= 1'b0;
      if (csb_s) begin
        // Deselect mid-frame is only an error once at least one bit has been clocked in.
        o_frame_err <= ((state_r == ADDR) || (state_r == DATA)) &&
                       (bit_cnt_r != {CNT_W{1'b0}});
        state_r     <= IDLE;
        bit_cnt_r   <= {CNT_W{1'b0}};
        addr_sh_r   <= {ADDR_W{1'b0}};
        data_sh_r   <= {DATA_W{1'b0}};
      end else begin
        case (state_r)
          IDLE: state_r <= ADDR;
          ADDR: begin
            if (rise_s) begin
              addr_sh_r <= ADDR_W'({addr_sh_r, mosi_s});
              bit_cnt_r <= bit_cnt_r + CNT_W'(1);
              if (bit_cnt_r == CNT_W'(ADDR_W - 1)) begin
                state_r <= DATA;
              end
            end
          end
          DATA: begin
            if (rise_s) begin
              data_sh_r <= word_s;
              bit_cnt_r <= bit_cnt_r + CNT_W'(1);
              if (last_bit_s) begin
                state_r     <= DONE;
                o_wr_strobe <= addr_ok_s;
                o_frame_err <= !addr_ok_s;
                if (addr_ok_s) begin
                  o_wr_addr <= addr_sh_r;
                end
              end
            end
          end
          DONE:    state_r <= DONE;
          default: state_r <= IDLE;
        endcase
      end
    end
  end

  // Register storage: commit moves dirty pending words live; a capture in the same
  // cycle overrides the dirty clear so the new word waits for the next commit.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        live_r[r] <= RESET_VAL[r*DATA_W +: DATA_W];
        pend_r[r] <= RESET_VAL[r*DATA_W +: DATA_W];
      end
      dirty_r   <= {NUM_REGS{1'b0}};
      o_pending <= 1'b0;
    end else begin
      o_pending <= |dirty_r;
      for (int r = 0; r < NUM_REGS; r++) begin
        if (i_commit && dirty_r[r]) begin
          live_r[r]  <= pend_r[r];
          dirty_r[r] <= 1'b0;
        end
        if (cap_s && (addr_sh_r == ADDR_W'(r))) begin
          if (IMMEDIATE_MASK[r]) begin
            live_r[r] <= word_s;
          end else begin
            pend_r[r]  <= word_s;
            dirty_r[r] <= 1'b1;
          end
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
    assign o_regs[g*DATA_W +: DATA_W] = live_r[g];
  end

endmodule

// File: tb/tb_spi_reg_bank.sv
// Randomised self-checking bench for spi_reg_bank against a frame-level register model.
module tb_spi_reg_bank;

  localparam int NR = 8;
  localparam int DW = 24;
  localparam int AW = 4;
  localparam logic [NR*DW-1:0] RV = {24'h777777, 24'h666666, 24'h555555, 24'h444444,
                                     24'h333333, 24'h222222, 24'h111111, 24'h0F0F0F};
  localparam logic [NR-1:0] IMM = 8'h01;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sclk = 1'b0;
  logic csb = 1'b1;
  logic mosi = 1'b0;
  logic commit = 1'b0;
  logic [NR*DW-1:0] regs;
  logic wr_strobe;
  logic [AW-1:0] wr_addr;
  logic pending;
  logic frame_err;

  int n_tests = 0;
  int n_fail = 0;
  int strobe_cnt = 0;
  int err_cnt = 0;
  logic [DW-1:0] reg0_at_strobe = '0;

  logic [DW-1:0] m_live [NR];
  logic [DW-1:0] m_pend [NR];
  logic [NR-1:0] m_dirty;
  logic [AW-1:0] m_addr;

  spi_reg_bank #(
    .NUM_REGS(NR), .DATA_W(DW), .ADDR_W(AW), .SYNC_STAGES(2),
    .IMMEDIATE_MASK(IMM), .RESET_VAL(RV)
  ) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_sclk(sclk), .i_csb(csb), .i_mosi(mosi),
    .i_commit(commit), .o_regs(regs), .o_wr_strobe(wr_strobe), .o_wr_addr(wr_addr),
    .o_pending(pending), .o_frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_strobe === 1'b1) begin
      strobe_cnt     <= strobe_cnt + 1;
      reg0_at_strobe <= regs[DW-1:0];
    end
    if (frame_err === 1'b1) err_cnt <= err_cnt + 1;
  end

  function automatic logic [NR*DW-1:0] model_regs();
    logic [NR*DW-1:0] v;
    for (int r = 0; r < NR; r++) v[r*DW +: DW] = m_live[r];
    return v;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < NR; r++) begin
      m_live[r] = RV[r*DW +: DW];
      m_pend[r] = RV[r*DW +: DW];
    end
    m_dirty = '0;
    m_addr  = '0;
  endtask

  task automatic model_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (a < NR) begin
      m_addr = a;
      if (IMM[a]) m_live[a] = d;
      else begin
        m_pend[a]  = d;
        m_dirty[a] = 1'b1;
      end
    end
  endtask

  task automatic model_commit();
    for (int r = 0; r < NR; r++) if (m_dirty[r]) m_live[r] = m_pend[r];
    m_dirty = '0;
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Mode-0 shifting, 8 clk per SCLK period; optionally holds i_commit over the last capture.
  task automatic shift_bits(input logic [63:0] bits, input int n, input bit commit_last,
                            output bit seen);
    seen = 1'b0;
    csb = 1'b0;
    clks(4);
    for (int i = n - 1; i >= 0; i--) begin
      mosi = bits[i];
      clks(4);
      if (commit_last && i == 0) begin
        commit = 1'b1;
        sclk = 1'b1;
        for (int k = 0; k < 40 && !seen; k++) begin
          clks(1);
          if (wr_strobe === 1'b1) seen = 1'b1;
        end
        commit = 1'b0;
        clks(1);
      end else begin
        sclk = 1'b1;
        clks(4);
      end
      sclk = 1'b0;
    end
  endtask

  task automatic end_frame();
    clks(2);
    csb = 1'b1;
    mosi = 1'b0;
    clks(8);
  endtask

  task automatic write_frame(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit seen;
    shift_bits({36'd0, a, d}, AW + DW, 1'b0, seen);
    end_frame();
    model_write(a, d);
  endtask

  task automatic do_commit();
    commit = 1'b1;
    clks(1);
    commit = 1'b0;
    model_commit();
    clks(3);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clks(3);
    rst_n = 1'b1;
    model_reset();
    clks(2);
    n_tests += 5;
    if (regs !== RV) begin n_fail++; $display("FAIL reset_regs got %h exp %h", regs, RV); end
    if (wr_strobe !== 1'b0) begin n_fail++; $display("FAIL reset_strobe got %b exp 0", wr_strobe); end
    if (wr_addr !== 4'd0) begin n_fail++; $display("FAIL reset_addr got %h exp 0", wr_addr); end
    if (pending !== 1'b0) begin n_fail++; $display("FAIL reset_pending got %b exp 0", pending); end
    if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b exp 0", frame_err); end
  endtask

  task automatic test_deferred();
    int s0 = strobe_cnt;
    write_frame(4'h3, 24'hA5C3F0);
    n_tests += 6;
    if (strobe_cnt - s0 != 1) begin n_fail++; $display("FAIL def_strobe got %0d exp 1", strobe_cnt - s0); end
    if (wr_addr !== 4'd3) begin n_fail++; $display("FAIL def_addr got %h exp 3", wr_addr); end
    if (pending !== 1'b1) begin n_fail++; $display("FAIL def_pending got %b exp 1", pending); end
    if (regs[3*DW +: DW] !== 24'h333333) begin n_fail++; $display("FAIL def_not_live got %h exp 333333", regs[3*DW +: DW]); end
    do_commit();
    if (regs[3*DW +: DW] !== 24'hA5C3F0) begin n_fail++; $display("FAIL def_commit got %h exp a5c3f0", regs[3*DW +: DW]); end
    if (pending !== 1'b0) begin n_fail++; $display("FAIL def_pending_clr got %b exp 0", pending); end
  endtask

  task automatic test_immediate();
    int s0 = strobe_cnt;
    write_frame(4'h0, 24'h000123);
    n_tests += 4;
    if (strobe_cnt - s0 != 1) begin n_fail++; $display("FAIL imm_strobe got %0d exp 1", strobe_cnt - s0); end
    if (reg0_at_strobe !== 24'h000123) begin n_fail++; $display("FAIL imm_at_strobe got %h exp 000123", reg0_at_strobe); end
    if (regs !== model_regs()) begin n_fail++; $display("FAIL imm_regs got %h exp %h", regs, model_regs()); end
    if (pending !== 1'b0) begin n_fail++; $display("FAIL imm_pending got %b exp 0", pending); end
  endtask

  task automatic test_short_frame();
    int s0, e0;
    bit seen;
    logic [DW-1:0] d = DW'($urandom);
    write_frame(4'h6, d);
    s0 = strobe_cnt;
    e0 = err_cnt;
    shift_bits({54'd0, 4'h6, 6'h2A}, 10, 1'b0, seen);
    end_frame();
    n_tests += 4;
    if (err_cnt - e0 != 1) begin n_fail++; $display("FAIL short_err got %0d exp 1", err_cnt - e0); end
    if (strobe_cnt - s0 != 0) begin n_fail++; $display("FAIL short_strobe got %0d exp 0", strobe_cnt - s0); end
    if (regs !== model_regs()) begin n_fail++; $display("FAIL short_regs got %h exp %h", regs, model_regs()); end
    do_commit();
    if (regs !== model_regs()) begin n_fail++; $display("FAIL short_pend got %h exp %h", regs, model_regs()); end
  endtask

  task automatic test_bad_addr();
    int s0 = strobe_cnt;
    int e0 = err_cnt;
    bit seen;
    logic [DW-1:0] d = DW'($urandom);
    write_frame(4'h9, d);
    n_tests += 7;
    if (err_cnt - e0 != 1) begin n_fail++; $display("FAIL bad_err got %0d exp 1", err_cnt - e0); end
    if (strobe_cnt - s0 != 0) begin n_fail++; $display("FAIL bad_strobe got %0d exp 0", strobe_cnt - s0); end
    if (wr_addr !== m_addr) begin n_fail++; $display("FAIL bad_addr_hold got %h exp %h", wr_addr, m_addr); end
    s0 = strobe_cnt;
    e0 = err_cnt;
    d = DW'($urandom);
    shift_bits({34'd0, 4'h4, d, 2'b11}, 30, 1'b0, seen);
    end_frame();
    model_write(4'h4, d);
    if (strobe_cnt - s0 != 1) begin n_fail++; $display("FAIL long_strobe got %0d exp 1", strobe_cnt - s0); end
    if (err_cnt - e0 != 0) begin n_fail++; $display("FAIL long_err got %0d exp 0", err_cnt - e0); end
    if (wr_addr !== 4'd4) begin n_fail++; $display("FAIL long_addr got %h exp 4", wr_addr); end
    do_commit();
    if (regs !== model_regs()) begin n_fail++; $display("FAIL long_regs got %h exp %h", regs, model_regs()); end
  endtask

  task automatic test_commit_capture();
    bit seen;
    logic [DW-1:0] d = DW'($urandom);
    do_commit();
    shift_bits({36'd0, 4'h5, d}, AW + DW, 1'b1, seen);
    end_frame();
    model_commit();
    model_write(4'h5, d);
    n_tests += 4;
    if (!seen) begin n_fail++; $display("FAIL cc_timeout got no strobe exp strobe"); end
    if (regs[5*DW +: DW] !== 24'h555555) begin n_fail++; $display("FAIL cc_unchanged got %h exp 555555", regs[5*DW +: DW]); end
    if (pending !== 1'b1) begin n_fail++; $display("FAIL cc_pending got %b exp 1", pending); end
    do_commit();
    if (regs[5*DW +: DW] !== d) begin n_fail++; $display("FAIL cc_next_commit got %h exp %h", regs[5*DW +: DW], d); end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] d1 = DW'($urandom);
    logic [DW-1:0] d2 = DW'($urandom);
    write_frame(4'h2, d1);
    write_frame(4'h7, d1);
    write_frame(4'h2, d2);
    do_commit();
    n_tests += 2;
    if (regs[2*DW +: DW] !== d2) begin n_fail++; $display("FAIL b2b_last_wins got %h exp %h", regs[2*DW +: DW], d2); end
    if (regs !== model_regs()) begin n_fail++; $display("FAIL b2b_regs got %h exp %h", regs, model_regs()); end
  endtask

  task automatic test_reset_mid();
    int e0 = err_cnt;
    int s0;
    bit seen;
    logic [DW-1:0] d = DW'($urandom);
    write_frame(4'h1, DW'($urandom));
    shift_bits({$urandom, $urandom}, 12, 1'b0, seen);
    rst_n = 1'b0;
    clks(2);
    csb = 1'b1;
    sclk = 1'b0;
    mosi = 1'b0;
    clks(2);
    rst_n = 1'b1;
    model_reset();
    clks(6);
    n_tests += 5;
    if (regs !== RV) begin n_fail++; $display("FAIL rmid_regs got %h exp %h", regs, RV); end
    if (pending !== 1'b0) begin n_fail++; $display("FAIL rmid_pending got %b exp 0", pending); end
    s0 = strobe_cnt;
    write_frame(4'h2, d);
    do_commit();
    if (strobe_cnt - s0 != 1) begin n_fail++; $display("FAIL rmid_strobe got %0d exp 1", strobe_cnt - s0); end
    if (err_cnt - e0 != 0) begin n_fail++; $display("FAIL rmid_err got %0d exp 0", err_cnt - e0); end
    if (regs[2*DW +: DW] !== d) begin n_fail++; $display("FAIL rmid_write got %h exp %h", regs[2*DW +: DW], d); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 40; it++) begin
      int s0 = strobe_cnt;
      int e0 = err_cnt;
      int exp_s = 0;
      int exp_e = 0;
      int op = $urandom_range(0, 9);
      bit seen;
      logic [AW-1:0] a = AW'($urandom_range(0, 9));
      logic [DW-1:0] d = DW'($urandom);
      if (op <= 5) begin
        write_frame(a, d);
        if (a < NR) exp_s = 1;
        else exp_e = 1;
      end else if (op <= 7) begin
        do_commit();
      end else if (op == 8) begin
        int n = $urandom_range(0, AW + DW - 1);
        shift_bits({$urandom, $urandom}, n, 1'b0, seen);
        end_frame();
        exp_e = (n > 0) ? 1 : 0;
      end else begin
        int x = $urandom_range(1, 3);
        a = AW'($urandom_range(0, NR - 1));
        shift_bits(({36'd0, a, d} << x) | 64'(x), AW + DW + x, 1'b0, seen);
        end_frame();
        model_write(a, d);
        exp_s = 1;
      end
      n_tests += 5;
      if (strobe_cnt - s0 != exp_s) begin n_fail++; $display("FAIL rnd%0d_strobe got %0d exp %0d", it, strobe_cnt - s0, exp_s); end
      if (err_cnt - e0 != exp_e) begin n_fail++; $display("FAIL rnd%0d_err got %0d exp %0d", it, err_cnt - e0, exp_e); end
      if (regs !== model_regs()) begin n_fail++; $display("FAIL rnd%0d_regs got %h exp %h", it, regs, model_regs()); end
      if (pending !== (|m_dirty)) begin n_fail++; $display("FAIL rnd%0d_pending got %b exp %b", it, pending, |m_dirty); end
      if (wr_addr !== m_addr) begin n_fail++; $display("FAIL rnd%0d_addr got %h exp %h", it, wr_addr, m_addr); end
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    test_reset();
    test_deferred();
    test_immediate();
    test_short_frame();
    test_bad_addr();
    test_commit_capture();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
